lfsr_word_capture: RTL and testbench

Serial-to-parallel capture stage sitting directly downstream of the lfsr4000 sizing chain. It samples the chain's serial output `q` on every enabled clock, packs bits MSB-first into WORD_W-bit words, and presents completed words on a valid/ready port. It also keeps a saturating word count, a sticky overrun flag and an optional MISR signature. The bench checks the chain with a single word or signature compare instead of reading bit dumps.

---
 rtl/lfsr_word_capture.sv | 128 ++++++++++++
 tb/tb_lfsr_word_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_word_capture.sv
// Serial-to-parallel capture of the LFSR chain output into valid/ready words with a saturating
// word count, sticky overrun flag and an optional 32-bit MISR (LFSR_CAPTURE_MISR_EN).
module lfsr_word_capture #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic              din_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [CNT_W-1:0]  word_count_o,
  output logic              overrun_o
`ifdef LFSR_CAPTURE_MISR_EN
  ,
  output logic [31:0]       sig_o
`endif
);

  localparam int unsigned IdxW = $clog2(WORD_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_W - 1);

  typedef enum logic [0:0] {StEmpty, StHold} out_state_e;

  out_state_e          state_q, state_d;
  logic [WORD_W-2:0]   shreg_q, shreg_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                overrun_q, overrun_d;
  logic [WORD_W-1:0]   new_word;
  logic                complete, load, drop;

  assign new_word = {shreg_q, din_i};
  assign complete = en_i && (idx_q == LastIdx);

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StEmpty;
      shreg_q   <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    load      = 1'b0;
    drop      = 1'b0;

    if (en_i) begin
      shreg_d = new_word[WORD_W-2:0];
      idx_d   = complete ? '0 : idx_q + IdxW'(1);
    end

    unique case (state_q)
      StEmpty: begin
        if (complete) begin
          load    = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        // A completion coinciding with consumption refills the holding register directly.
        if (complete && word_ready_i) begin
          load = 1'b1;
        end else if (complete) begin
          drop = 1'b1;
        end else if (word_ready_i) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase

    word_d    = load ? new_word : word_q;
    cnt_d     = (load && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    overrun_d = overrun_q | drop;
  end

  // Outputs
  always_comb begin
    word_valid_o = (state_q == StHold);
    word_o       = word_q;
    word_count_o = cnt_q;
    overrun_o    = overrun_q;
  end

`ifdef LFSR_CAPTURE_MISR_EN
  logic [31:0] sig_q, sig_d;
  logic [31:0] word32;

  assign word32 = 32'(new_word);

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? 32'h0040_0007 : 32'h0)) ^ word32;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;
`endif

endmodule

// File: tb/tb_lfsr_word_capture.sv
// Scoreboard bench for lfsr_word_capture: stimulus pushes expected words, a negedge monitor
// pops and compares each newly presented word. CNT_W=2 so count saturation is reachable.
module tb_lfsr_word_capture;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 2;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  cnt;
    logic [31:0] sig;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              en;
  logic              din;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;
  logic [CNT_W-1:0]  word_count;
  logic              overrun;
  logic [31:0]       sig;

  int n_vec;
  int n_err;
  int valid_cycles;
  logic [31:0] model_sig;
  exp_t exp_q[$];

  lfsr_word_capture #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .en_i         (en),
    .din_i        (din),
    .word_o       (word),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .word_count_o (word_count),
    .overrun_o    (overrun)
`ifdef LFSR_CAPTURE_MISR_EN
    ,
    .sig_o        (sig)
`endif
  );

`ifndef LFSR_CAPTURE_MISR_EN
  assign sig = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] w);
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0)) ^ w;
  endfunction

  // Push an expected load, tracking the MISR the bench expects after it.
  task automatic expect_word(input logic [31:0] w, input logic [1:0] c);
    exp_t e;
    model_sig = misr(model_sig, w);
    e.word = w;
    e.cnt  = c;
    e.sig  = model_sig;
    exp_q.push_back(e);
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    en  = 1'b1;
    din = b;
    edge_tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    edge_tick();
    reset_n   = 1'b1;
    model_sig = '0;
  endtask

  // Monitor: a word is newly presented when valid rises or a handshake refilled it.
  logic prev_valid, prev_hs;
  initial begin
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
  end
  always @(negedge clk) begin
    if (word_valid) valid_cycles++;
    if (word_valid && (!prev_valid || prev_hs)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(word), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_word", 64'(word), 64'(e.word));
        check("sb_count", 64'(word_count), 64'(e.cnt));
`ifdef LFSR_CAPTURE_MISR_EN
        check("sb_sig", 64'(sig), 64'(e.sig));
`endif
      end
    end
    prev_valid = word_valid;
    prev_hs    = word_valid && word_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    n_vec      = 0;
    n_err      = 0;
    model_sig  = '0;
    reset_n    = 1'b0;
    en         = 1'b1;
    din        = 1'b0;
    word_ready = 1'b0;

    // Reset with enable active and random data
    for (int i = 0; i < 2; i++) begin
      din = 1'($urandom);
      edge_tick();
    end
    check("rst_word", 64'(word), 64'h0);
    check("rst_valid", 64'(word_valid), 64'h0);
    check("rst_count", 64'(word_count), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
`ifdef LFSR_CAPTURE_MISR_EN
    check("rst_sig", 64'(sig), 64'h0);
`endif
    reset_n = 1'b1;

    // Single word then one-edge consume
    expect_word(32'hA5A5_0F0F, 2'd1);
    send_word(32'hA5A5_0F0F);
    check("single_word", 64'(word), 64'hA5A5_0F0F);
    check("single_valid", 64'(word_valid), 64'h1);
    check("single_count", 64'(word_count), 64'h1);
    en         = 1'b0;
    word_ready = 1'b1;
    edge_tick();
    word_ready = 1'b0;
    check("consume_valid", 64'(word_valid), 64'h0);
    edge_tick();
    check("ready_no_valid", 64'(word_valid), 64'h0);

    // Enable gap of 5 edges after bit 10
    do_reset();
    expect_word(32'hA5A5_0F0F, 2'd1);
    pat = 32'hA5A5_0F0F;
    for (int i = 31; i >= 21; i--) send_bit(pat[i]);
    en = 1'b0;
    for (int i = 0; i < 5; i++) edge_tick();
    for (int i = 20; i >= 1; i--) send_bit(pat[i]);
    check("gap_valid_edge36", 64'(word_valid), 64'h0);
    send_bit(pat[0]);
    check("gap_valid_edge37", 64'(word_valid), 64'h1);
    check("gap_word", 64'(word), 64'hA5A5_0F0F);

    // Overrun: second word dropped while holding
    do_reset();
    expect_word(32'hFFFF_FFFF, 2'd1);
    send_word(32'hFFFF_FFFF);
    check("ovr_clear_first", 64'(overrun), 64'h0);
    send_word(32'h0000_0000);
    check("ovr_word", 64'(word), 64'hFFFF_FFFF);
    check("ovr_flag", 64'(overrun), 64'h1);
    check("ovr_count", 64'(word_count), 64'h1);
    check("ovr_valid", 64'(word_valid), 64'h1);

    // Back-to-back with ready held high
    do_reset();
    word_ready   = 1'b1;
    valid_cycles = 0;
    expect_word(32'h1, 2'd1);
    expect_word(32'h2, 2'd2);
    expect_word(32'h3, 2'd3);
    for (int w = 1; w <= 3; w++) begin
      send_word(32'(w));
`ifdef LFSR_CAPTURE_MISR_EN
      if (w == 1) check("b2b_sig1", 64'(sig), 64'h1);
      if (w == 2) check("b2b_sig2", 64'(sig), 64'h0);
      if (w == 3) check("b2b_sig3", 64'(sig), 64'h3);
`endif
    end
    en = 1'b0;
    edge_tick();
    check("b2b_pulses", 64'(valid_cycles), 64'd3);
    check("b2b_count", 64'(word_count), 64'd3);
    check("b2b_overrun", 64'(overrun), 64'h0);
    check("b2b_valid_end", 64'(word_valid), 64'h0);

    // Two more words: count must hold at all-ones
    expect_word(32'h4, 2'd3);
    expect_word(32'h5, 2'd3);
    send_word(32'h4);
    send_word(32'h5);
    check("sat_count", 64'(word_count), 64'd3);
    word_ready = 1'b0;

    // Mid-word reset discards the partial word
    do_reset();
    for (int i = 0; i < 17; i++) send_bit(1'($urandom));
    reset_n = 1'b0;
    send_bit(1'b1);
    reset_n   = 1'b1;
    model_sig = '0;
    expect_word(32'h1234_5678, 2'd1);
    send_word(32'h1234_5678);
    check("mid_rst_word", 64'(word), 64'h1234_5678);
    check("mid_rst_count", 64'(word_count), 64'h1);
    check("mid_rst_valid", 64'(word_valid), 64'h1);

    edge_tick();
    check("sb_leftover", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
